// File: rtl/chess_clock_if.sv
// Signal bundle between the chess clock and the board controller / display stage.
interface chess_clock_if;
  logic        start;
  logic        move_done;
  logic        pause;
  logic        clear;
  logic [15:0] code;
  logic        white_to_move;
  logic        running;
  logic        white_flag;
  logic        black_flag;

  // Controller side: issues game commands and watches the clock outputs.
  modport master (
    output start, move_done, pause, clear,
    input  code, white_to_move, running, white_flag, black_flag
  );

  // Clock side: receives game commands and drives the display code and status.
  modport slave (
    input  start, move_done, pause, clear,
    output code, white_to_move, running, white_flag, black_flag
  );
endinterface

// File: rtl/chess_clock.sv
// Two-player countdown chess clock. Each side's remaining time is held as BCD
// mm:ss and decremented once per clock second, derived from clk50 through a
// prescaler. The displayed code and status flags are registered copies of the
// internal state, so they all lag that state by exactly one cycle together.
module chess_clock #(
  parameter int         CLK_HZ   = 50_000_000,
  parameter logic [7:0] INIT_MIN = 8'h05,
  parameter logic [7:0] INIT_SEC = 8'h00
) (
  input logic          clk50,
  input logic          reset_n,
  chess_clock_if.slave bus
);

  localparam int              PW        = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0]   TERM      = PW'(CLK_HZ - 1);
  localparam logic [15:0]     INIT_TIME = {INIT_MIN, INIT_SEC};

  typedef enum logic [1:0] {IDLE, RUN_W, RUN_B, TIMEOUT} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [15:0]   whiteTime_q, whiteTime_d;
  logic [15:0]   blackTime_q, blackTime_d;
  logic          whiteSide_q, whiteSide_d;
  logic          whiteExp_q, whiteExp_d;
  logic          blackExp_q, blackExp_d;

  logic [15:0]   code_q, code_d;
  logic          whiteToMove_q, whiteToMove_d;
  logic          running_q, running_d;
  logic          whiteFlag_q, whiteFlag_d;
  logic          blackFlag_q, blackFlag_d;

  logic          tick;
  logic [15:0]   decTime;

  // One-second BCD countdown with borrow through every digit; 00:00 stays 00:00.
  function automatic logic [15:0] bcdDec(input logic [15:0] t);
    logic [3:0] m1, m0, s1, s0;
    {m1, m0, s1, s0} = t;
    if (t == 16'h0000) begin
      return t;
    end
    if (s0 != 4'd0) begin
      s0 = s0 - 4'd1;
    end else begin
      s0 = 4'd9;
      if (s1 != 4'd0) begin
        s1 = s1 - 4'd1;
      end else begin
        s1 = 4'd5;
        if (m0 != 4'd0) begin
          m0 = m0 - 4'd1;
        end else begin
          m0 = 4'd9;
          m1 = m1 - 4'd1;
        end
      end
    end
    return {m1, m0, s1, s0};
  endfunction

  // Next-state logic: clear dominates, then the game state decides how start,
  // move_done, pause and the one-second tick interact.
  always_comb begin
    state_d     = state_q;
    presc_d     = presc_q;
    whiteTime_d = whiteTime_q;
    blackTime_d = blackTime_q;
    whiteSide_d = whiteSide_q;
    whiteExp_d  = whiteExp_q;
    blackExp_d  = blackExp_q;
    tick        = (presc_q == TERM);
    decTime     = bcdDec(whiteSide_q ? whiteTime_q : blackTime_q);

    if (bus.clear) begin
      state_d     = IDLE;
      presc_d     = '0;
      whiteTime_d = INIT_TIME;
      blackTime_d = INIT_TIME;
      whiteSide_d = 1'b1;
      whiteExp_d  = 1'b0;
      blackExp_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            presc_d     = '0;
            whiteSide_d = 1'b1;
            if (INIT_TIME == 16'h0000) begin
              state_d    = TIMEOUT;
              whiteExp_d = 1'b1;
            end else begin
              state_d = RUN_W;
            end
          end
        end
        RUN_W, RUN_B: begin
          if (!bus.pause) begin
            presc_d = tick ? '0 : presc_q + PW'(1);
            if (tick) begin
              if (whiteSide_q) whiteTime_d = decTime;
              else             blackTime_d = decTime;
            end
            if (tick && decTime == 16'h0000) begin
              state_d = TIMEOUT;
              if (whiteSide_q) whiteExp_d = 1'b1;
              else             blackExp_d = 1'b1;
            end else if (bus.move_done) begin
              presc_d     = '0;
              whiteSide_d = !whiteSide_q;
              state_d     = whiteSide_q ? RUN_B : RUN_W;
            end
          end
        end
        default: begin
        end
      endcase
    end

    code_d        = whiteSide_q ? whiteTime_q : blackTime_q;
    whiteToMove_d = whiteSide_q;
    running_d     = (state_q == RUN_W || state_q == RUN_B) && !bus.pause;
    whiteFlag_d   = whiteExp_q;
    blackFlag_d   = blackExp_q;
  end

  // State and output registers; outputs are snapshots of the previous state.
  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      presc_q       <= '0;
      whiteTime_q   <= INIT_TIME;
      blackTime_q   <= INIT_TIME;
      whiteSide_q   <= 1'b1;
      whiteExp_q    <= 1'b0;
      blackExp_q    <= 1'b0;
      code_q        <= INIT_TIME;
      whiteToMove_q <= 1'b1;
      running_q     <= 1'b0;
      whiteFlag_q   <= 1'b0;
      blackFlag_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      presc_q       <= presc_d;
      whiteTime_q   <= whiteTime_d;
      blackTime_q   <= blackTime_d;
      whiteSide_q   <= whiteSide_d;
      whiteExp_q    <= whiteExp_d;
      blackExp_q    <= blackExp_d;
      code_q        <= code_d;
      whiteToMove_q <= whiteToMove_d;
      running_q     <= running_d;
      whiteFlag_q   <= whiteFlag_d;
      blackFlag_q   <= blackFlag_d;
    end
  end

  assign bus.code          = code_q;
  assign bus.white_to_move = whiteToMove_q;
  assign bus.running       = running_q;
  assign bus.white_flag    = whiteFlag_q;
  assign bus.black_flag    = blackFlag_q;

endmodule

// File: tb/tb_chess_clock.sv
// Bench for the chess clock: a seconds-based game model predicts every output
// cycle, a monitor compares the DUT against those predictions each cycle.
module tb_chess_clock;

  localparam int CLK_HZ     = 4;
  localparam int INIT_TOTAL = 300;

  localparam int M_IDLE    = 0;
  localparam int M_RUN     = 1;
  localparam int M_TIMEOUT = 2;

  logic clk50   = 1'b0;
  logic reset_n = 1'b0;

  chess_clock_if bus();
  chess_clock_if busZero();

  chess_clock #(.CLK_HZ(CLK_HZ), .INIT_MIN(8'h05), .INIT_SEC(8'h00)) dut (
    .clk50  (clk50),
    .reset_n(reset_n),
    .bus    (bus)
  );

  chess_clock #(.CLK_HZ(CLK_HZ), .INIT_MIN(8'h00), .INIT_SEC(8'h00)) dutZero (
    .clk50  (clk50),
    .reset_n(reset_n),
    .bus    (busZero)
  );

  typedef struct packed {
    logic [15:0] code;
    logic        wtm;
    logic        running;
    logic        wflag;
    logic        bflag;
  } obs_t;

  obs_t expQ[$];
  int   compared   = 0;
  int   mismatched = 0;

  int mMode;
  bit mWhite;
  int wSec;
  int bSec;
  int mPresc;
  bit wFlag;
  bit bFlag;

  // Free-running 50 MHz-style clock, 10 time units per period.
  always #5 clk50 = ~clk50;

  function automatic logic [15:0] toBcd(input int sec);
    int m;
    int s;
    m = sec / 60;
    s = sec % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic obs_t resetObs();
    obs_t o;
    o.code    = toBcd(INIT_TOTAL);
    o.wtm     = 1'b1;
    o.running = 1'b0;
    o.wflag   = 1'b0;
    o.bflag   = 1'b0;
    return o;
  endfunction

  task automatic modelReset();
    mMode  = M_IDLE;
    mWhite = 1'b1;
    wSec   = INIT_TOTAL;
    bSec   = INIT_TOTAL;
    mPresc = 0;
    wFlag  = 1'b0;
    bFlag  = 1'b0;
  endtask

  // One clock edge of the game rules, expressed in whole seconds.
  task automatic modelStep(input logic st, input logic mv, input logic pa, input logic cl);
    bit tick;
    if (cl) begin
      modelReset();
      return;
    end
    case (mMode)
      M_IDLE: begin
        if (st) begin
          mMode  = M_RUN;
          mWhite = 1'b1;
          mPresc = 0;
        end
      end
      M_RUN: begin
        if (!pa) begin
          tick   = (mPresc == CLK_HZ - 1);
          mPresc = tick ? 0 : mPresc + 1;
          if (tick) begin
            if (mWhite) wSec = wSec - 1;
            else        bSec = bSec - 1;
            if ((mWhite ? wSec : bSec) == 0) begin
              if (mWhite) wFlag = 1'b1;
              else        bFlag = 1'b1;
              mMode = M_TIMEOUT;
              return;
            end
          end
          if (mv) begin
            mWhite = !mWhite;
            mPresc = 0;
          end
        end
      end
      default: begin
      end
    endcase
  endtask

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: predict what the registered outputs show after this edge,
  // then advance the model with the inputs sampled at this edge.
  always @(posedge clk50 or negedge reset_n) begin
    obs_t e;
    if (!reset_n) begin
      modelReset();
      expQ.delete();
    end else begin
      e.code    = toBcd(mWhite ? wSec : bSec);
      e.wtm     = mWhite;
      e.running = (mMode == M_RUN) && !bus.pause;
      e.wflag   = wFlag;
      e.bflag   = bFlag;
      expQ.push_back(e);
      modelStep(bus.start, bus.move_done, bus.pause, bus.clear);
    end
  end

  // Monitor: every falling edge the DUT presents a fresh output word.
  always @(negedge clk50) begin
    obs_t exp;
    if (!reset_n || expQ.size() == 0) exp = resetObs();
    else                              exp = expQ.pop_front();
    checkOutput("code",          bus.code,                  exp.code);
    checkOutput("white_to_move", {15'd0, bus.white_to_move}, {15'd0, exp.wtm});
    checkOutput("running",       {15'd0, bus.running},       {15'd0, exp.running});
    checkOutput("white_flag",    {15'd0, bus.white_flag},    {15'd0, exp.wflag});
    checkOutput("black_flag",    {15'd0, bus.black_flag},    {15'd0, exp.bflag});
  end

  task automatic waitEdge();
    @(posedge clk50);
    #2;
  endtask

  task automatic driveInputs(input logic st, input logic mv, input logic pa, input logic cl);
    bus.start     = st;
    bus.move_done = mv;
    bus.pause     = pa;
    bus.clear     = cl;
  endtask

  task automatic applyStimulus(input logic st, input logic mv, input logic pa, input logic cl);
    waitEdge();
    driveInputs(st, mv, pa, cl);
  endtask

  // Run white's clock out with no pauses, inserting the coincident tick/move cases.
  task automatic drainWhite();
    bit did5;
    bit mv;
    did5 = 1'b0;
    for (int c = 0; c < 3000 && mMode != M_TIMEOUT; c++) begin
      waitEdge();
      mv = 1'b0;
      if (mMode == M_RUN && mWhite && mPresc == CLK_HZ - 1) begin
        if (wSec == 5 && !did5) begin
          mv   = 1'b1;
          did5 = 1'b1;
        end else if (wSec == 1) begin
          mv = 1'b1;
        end
      end else if (mMode == M_RUN && !mWhite && mPresc == 1) begin
        mv = 1'b1;
      end
      driveInputs(1'b0, mv, 1'b0, 1'b0);
    end
    compared++;
    if (mMode != M_TIMEOUT) begin
      mismatched++;
      $display("[TB] FAIL drain_timeout: white never expired within cycle budget");
    end
  endtask

  // Main stimulus sequence: directed scenarios followed by a randomized game.
  initial begin
    bit pa;
    driveInputs(1'b0, 1'b0, 1'b0, 1'b0);
    busZero.start     = 1'b0;
    busZero.move_done = 1'b0;
    busZero.pause     = 1'b0;
    busZero.clear     = 1'b0;
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    busZero.start = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    busZero.start = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("zero_init_flag",    {15'd0, busZero.white_flag}, 16'd1);
    checkOutput("zero_init_code",    busZero.code,                16'h0000);
    checkOutput("zero_init_running", {15'd0, busZero.running},    16'd0);

    repeat (12) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (9) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (6) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 10; i++) applyStimulus(1'b0, (i == 4), 1'b1, 1'b0);
    repeat (8) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    drainWhite();
    for (int i = 0; i < 12; i++) applyStimulus(1'(i % 3 == 0), 1'(i % 2), 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    repeat (4) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (5) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (7) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b0;
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    pa = 1'b0;
    for (int c = 0; c < 5000; c++) begin
      if ($urandom_range(24) == 0) pa = !pa;
      applyStimulus(1'($urandom_range(39) == 0), 1'($urandom_range(11) == 0),
                    pa, 1'($urandom_range(1499) == 0));
    end

    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
